// File: rtl/vga_pkg.sv
// Shared constants for the 800x600 VGA pipeline and the vblank update scheduler.
package vga_pkg;

  // Visible raster size in pixels and lines
  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 600;

  // Scheduler defaults
  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_MAX_GRANT = 512;
  localparam int unsigned DEF_FCNT_W    = 16;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;

endpackage

// File: rtl/vblank_update_sched_rr_pick.sv
// Round-robin picker: first set bit of the candidate vector at or after the
// pointer, wrapping around. Purely combinational.
module rr_pick
  import vga_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_cand,
  input  logic [PW-1:0]    i_rr_ptr,
  output logic             o_valid,
  output logic [N_REQ-1:0] o_pick,
  output logic [PW-1:0]    o_index
);

  // Scan candidates starting at the pointer; the first hit wins
  always_comb begin
    o_valid = 1'b0;
    o_pick  = '0;
    o_index = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!o_valid && i_cand[PW'((32'(i_rr_ptr) + k) % N_REQ)]) begin
        o_valid = 1'b1;
        o_pick[PW'((32'(i_rr_ptr) + k) % N_REQ)] = 1'b1;
        o_index = PW'((32'(i_rr_ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/vblank_update_sched.sv
// Frame-level scheduler: opens an update window at every vblank rise and hands
// it, one requester at a time and round-robin, to blocks rewriting shared draw
// registers so updates never tear a visible frame.
module vblank_update_sched
  import vga_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned MAX_GRANT = DEF_MAX_GRANT,
  parameter int unsigned FCNT_W    = DEF_FCNT_W
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk_in,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  done,
  output logic [N_REQ-1:0]  grant,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              busy,
  output logic              timeout,
  output logic              overrun
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned HW = $clog2(MAX_GRANT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_GRANT - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);

  logic [1:0]        r_state;
  logic              r_vblnk_q;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_gidx;
  logic [N_REQ-1:0]  r_served;
  logic [HW-1:0]     r_hold_cnt;
  logic [N_REQ-1:0]  r_grant;
  logic              r_tick;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_timeout;
  logic              r_overrun;

  logic              w_rise;
  logic [N_REQ-1:0]  w_cand;
  logic              w_valid;
  logic [N_REQ-1:0]  w_pick;
  logic [PW-1:0]     w_idx;
  logic [PW-1:0]     w_next_ptr;

  assign w_rise     = vblnk_in & ~r_vblnk_q;
  assign w_cand     = req & ~r_served;
  assign w_next_ptr = (w_idx == PTR_LAST) ? '0 : w_idx + 1'b1;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .i_cand   (w_cand),
    .i_rr_ptr (r_rr_ptr),
    .o_valid  (w_valid),
    .o_pick   (w_pick),
    .o_index  (w_idx)
  );

  // Edge detect, window FSM, grant hold counter and registered outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vblnk_q   <= 1'b0;
      r_rr_ptr    <= '0;
      r_gidx      <= '0;
      r_served    <= '0;
      r_hold_cnt  <= '0;
      r_grant     <= '0;
      r_tick      <= 1'b0;
      r_frame_cnt <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_vblnk_q <= vblnk_in;
      r_tick    <= 1'b0;
      r_timeout <= 1'b0;
      r_overrun <= 1'b0;
      // A rise restarts the window from any state, including a vblank glitch
      if (w_rise) begin
        r_tick      <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_served    <= '0;
        r_grant     <= '0;
        r_state     <= ST_ARB;
      end else begin
        case (r_state)
          ST_ARB: begin
            if (!vblnk_in || !w_valid) begin
              r_state <= ST_IDLE;
            end else begin
              r_grant    <= w_pick;
              r_served   <= r_served | w_pick;
              r_gidx     <= w_idx;
              r_rr_ptr   <= w_next_ptr;
              r_hold_cnt <= '0;
              r_state    <= ST_GRANT;
            end
          end
          ST_GRANT: begin
            if (!vblnk_in) begin
              r_grant   <= '0;
              r_overrun <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (done[r_gidx]) begin
              r_grant <= '0;
              r_state <= ST_ARB;
            end else if (r_hold_cnt == HOLD_LAST) begin
              r_grant   <= '0;
              r_timeout <= 1'b1;
              r_state   <= ST_ARB;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign grant      = r_grant;
  assign frame_tick = r_tick;
  assign frame_cnt  = r_frame_cnt;
  assign busy       = (r_state != ST_IDLE);
  assign timeout    = r_timeout;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_vblank_update_sched.sv
// Directed bench for vblank_update_sched: inputs change and outputs are
// sampled on the falling edge of pclk.
module tb_vblank_update_sched;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vblnk_in;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [3:0]  grant;
  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        busy;
  logic        timeout;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  vblank_update_sched #(
    .N_REQ     (4),
    .MAX_GRANT (512),
    .FCNT_W    (16)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .vblnk_in   (vblnk_in),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt),
    .busy       (busy),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic test_reset();
    rst = 1'b1; vblnk_in = 1'b0; req = '0; done = '0;
    step(3);
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (timeout !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", timeout, overrun); end
    rst = 1'b0;
    step(1);
  endtask

  // req=1010, each grantee holds for 5 cycles before done
  task automatic test_two_req();
    logic [3:0] exp_g [2];
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000;
    req = 4'b1010; vblnk_in = 1'b1;
    step(1);
    total++; if (frame_tick !== 1'b1) begin bad++; $display("FAIL t2_tick got=%b exp=1", frame_tick); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL t2_cnt got=%0d exp=1", frame_cnt); end
    total++; if (busy !== 1'b1 || grant !== 4'b0000) begin bad++; $display("FAIL t2_arb got busy=%b grant=%b exp busy=1 grant=0000", busy, grant); end
    step(1);
    total++; if (frame_tick !== 1'b0) begin bad++; $display("FAIL t2_tick_off got=%b exp=0", frame_tick); end
    for (int g = 0; g < 2; g++) begin
      for (int c = 0; c < 5; c++) begin
        total++; if (grant !== exp_g[g]) begin bad++; $display("FAIL t2_grant%0d_c%0d got=%b exp=%b", g, c, grant, exp_g[g]); end
        if (c == 4) done = exp_g[g];
        step(1);
      end
      done = '0;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL t2_release%0d got=%b exp=0000", g, grant); end
      step(1);
    end
    total++; if (busy !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL t2_idle got busy=%b grant=%b exp busy=0 grant=0000", busy, grant); end
  endtask

  // all four request; done one cycle into each grant; order from rr_ptr=0
  task automatic test_round_robin();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000;
    vblnk_in = 1'b0; step(1);
    req = 4'b1111; vblnk_in = 1'b1; step(1);
    total++; if (frame_cnt !== 16'd2 || frame_tick !== 1'b1) begin bad++; $display("FAIL t3_frame got cnt=%0d tick=%b exp cnt=2 tick=1", frame_cnt, frame_tick); end
    step(1);
    for (int g = 0; g < 4; g++) begin
      total++; if (grant !== exp_g[g]) begin bad++; $display("FAIL t3_grant%0d got=%b exp=%b", g, grant, exp_g[g]); end
      done = exp_g[g];
      step(1);
      done = '0;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL t3_gap%0d got=%b exp=0000", g, grant); end
      step(1);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t3_idle got=%b exp=0", busy); end
  endtask

  // single requester never signals done: forced release after 512 cycles
  task automatic test_timeout();
    int held;
    vblnk_in = 1'b0; req = 4'b0001; step(1);
    vblnk_in = 1'b1; step(2);
    held = 0;
    while (grant === 4'b0001 && held < 700) begin
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL t4_early_timeout at=%0d got=1 exp=0", held); end
      held++;
      step(1);
    end
    total++; if (held !== 512) begin bad++; $display("FAIL t4_hold_len got=%0d exp=512", held); end
    total++; if (timeout !== 1'b1 || grant !== 4'b0000) begin bad++; $display("FAIL t4_timeout got to=%b grant=%b exp to=1 grant=0000", timeout, grant); end
    step(1);
    total++; if (timeout !== 1'b0 || busy !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL t4_after got to=%b busy=%b grant=%b exp 0 0 0000", timeout, busy, grant); end
  endtask

  // vblank ends mid-grant; stray done bits on other requesters are ignored
  task automatic test_overrun();
    vblnk_in = 1'b0; req = 4'b0100; step(1);
    vblnk_in = 1'b1; step(2);
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL t5_grant got=%b exp=0100", grant); end
    done = 4'b1011; req = 4'b0000; step(2);
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL t5_ignore got=%b exp=0100", grant); end
    done = '0; req = 4'b0100; vblnk_in = 1'b0; step(1);
    total++; if (grant !== 4'b0000 || overrun !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL t5_overrun got grant=%b ov=%b busy=%b exp 0000 1 0", grant, overrun, busy); end
    step(1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL t5_ov_pulse got=%b exp=0", overrun); end
    for (int c = 0; c < 5; c++) begin
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL t5_nogrant_c%0d got=%b exp=0000", c, grant); end
      step(1);
    end
  endtask

  // frame counter wrap, then reset while a grant is held
  task automatic test_wrap_and_reset();
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    step(1);
    total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL t6_preset got=%h exp=ffff", frame_cnt); end
    req = 4'b1001; vblnk_in = 1'b1; step(1);
    total++; if (frame_cnt !== 16'h0000 || frame_tick !== 1'b1) begin bad++; $display("FAIL t6_wrap got cnt=%h tick=%b exp 0000 1", frame_cnt, frame_tick); end
    step(1);
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL t6_rr_ptr3 got=%b exp=1000", grant); end
    step(1);
    rst = 1'b1; step(1);
    total++; if (grant !== 4'b0000 || busy !== 1'b0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL t6_rst got grant=%b busy=%b cnt=%0d exp 0000 0 0", grant, busy, frame_cnt); end
    rst = 1'b0; vblnk_in = 1'b0; req = '0; step(1);
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_round_robin();
    test_timeout();
    test_overrun();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
